// File: rtl/friscv_arb_pkg.sv
// Shared types and widths for the memory read arbiter.
package friscv_arb_pkg;

  localparam int unsigned AXI_ADDR_W = 10;
  localparam int unsigned AXI_ID_W   = 8;
  localparam int unsigned AXI_DATA_W = 128;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_fsm_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    S0   = 2'd1,
    S1   = 2'd2
  } grant_t;

  // AR fields forwarded from the granted requester to memory
  typedef struct packed {
    logic [AXI_ADDR_W-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [2:0]            arprot;
    logic [AXI_ID_W-1:0]   arid;
  } ar_bundle_t;

endpackage

// File: rtl/friscv_mem_rd_arbiter_if.sv
// AXI4 read-only channel bundle (AR + R).
interface friscv_mem_rd_arbiter_if;
  import friscv_arb_pkg::*;

  logic                  arvalid;
  logic                  arready;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [2:0]            arprot;
  logic [3:0]            arcache;
  logic [AXI_ID_W-1:0]   arid;
  logic                  arlock;
  logic [3:0]            arqos;
  logic [3:0]            arregion;
  logic                  rvalid;
  logic                  rready;
  logic [AXI_ID_W-1:0]   rid;
  logic [1:0]            rresp;
  logic [AXI_DATA_W-1:0] rdata;
  logic                  rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arprot, arcache, arid,
           arlock, arqos, arregion, rready,
    input  arready, rvalid, rid, rresp, rdata, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arprot, arcache, arid,
           arlock, arqos, arregion, rready,
    output arready, rvalid, rid, rresp, rdata, rlast
  );

endinterface

// File: rtl/friscv_rr_arbiter.sv
// Two-way request arbiter: round-robin pointer, or fixed priority to req[1].
module friscv_rr_arbiter (
  input  logic       aclk,
  input  logic       srst,
  input  logic [1:0] req,
  input  logic       prio_en,
  input  logic       advance,
  output logic [1:0] gnt_c
);

  // ptr=0: req[0] wins the next tie; ptr=1: req[1] wins it
  logic ptr;

  // One-hot grant; ties resolved by priority mode or pointer
  always_comb begin
    gnt_c = req;
    if (req == 2'b11) begin
      gnt_c = (prio_en || ptr) ? 2'b10 : 2'b01;
    end
  end

  // Pointer moves past whichever requester was just granted
  always_ff @(posedge aclk) begin
    if (srst) begin
      ptr <= 1'b0;
    end else if (advance && (gnt_c != 2'b00)) begin
      ptr <= gnt_c[0];
    end
  end

endmodule

// File: rtl/friscv_mem_rd_arbiter.sv
// Shares one AXI4 read port between the icache (s0) and dcache (s1) memctrls.
// Build option: FRISCV_ARB_DCACHE_PRIO_EN gives s1 fixed priority on ties.
module friscv_mem_rd_arbiter
  import friscv_arb_pkg::*;
#(
  parameter int unsigned         OSTDREQ_NUM = 4,
  parameter logic [AXI_ID_W-1:0] S0_ID_MASK  = AXI_ID_W'('h10),
  parameter logic [AXI_ID_W-1:0] S1_ID_MASK  = AXI_ID_W'('h20)
)(
  input  logic                           aclk,
  input  logic                           srst,
  friscv_mem_rd_arbiter_if.slave         s0,
  friscv_mem_rd_arbiter_if.slave         s1,
  friscv_mem_rd_arbiter_if.master        mem,
  output logic                           rid_err
);

  localparam int unsigned     CNT_W   = $clog2(OSTDREQ_NUM) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OSTDREQ_NUM);

`ifdef FRISCV_ARB_DCACHE_PRIO_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  arb_fsm_t         state;
  grant_t           grant;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [1:0]       req_c;
  logic [1:0]       gnt_c;
  logic             ar_hs_c;
  logic             hit0_c;
  logic             hit1_c;
  logic             rv0_c;
  logic             rv1_c;
  logic             inc0_c;
  logic             inc1_c;
  logic             dec0_c;
  logic             dec1_c;
  ar_bundle_t       s0_ar_c;
  ar_bundle_t       s1_ar_c;
  ar_bundle_t       mem_ar_c;
  logic             ar_unused;

  // Requester is eligible only while it has room for another outstanding read
  assign req_c = {s1.arvalid && (cnt1 < CNT_MAX), s0.arvalid && (cnt0 < CNT_MAX)};

  friscv_rr_arbiter u_rr_arbiter (
    .aclk    (aclk),
    .srst    (srst),
    .req     (req_c),
    .prio_en (PRIO_EN),
    .advance (state == IDLE),
    .gnt_c   (gnt_c)
  );

  // Grant FSM: latch a winner in IDLE, hold it until the memory AR handshake
  always_ff @(posedge aclk) begin
    if (srst) begin
      state <= IDLE;
      grant <= NONE;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_c != 2'b00) begin
            state <= LOCK;
            grant <= gnt_c[1] ? S1 : S0;
          end
        end
        LOCK: begin
          if (mem.arready) begin
            state <= IDLE;
            grant <= NONE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= NONE;
        end
      endcase
    end
  end

  // AR payload mux toward memory; attributes the memory does not use are tied off
  always_comb begin
    s0_ar_c  = '{araddr: s0.araddr, arlen: s0.arlen, arsize: s0.arsize,
                 arburst: s0.arburst, arprot: s0.arprot, arid: s0.arid};
    s1_ar_c  = '{araddr: s1.araddr, arlen: s1.arlen, arsize: s1.arsize,
                 arburst: s1.arburst, arprot: s1.arprot, arid: s1.arid};
    mem_ar_c = (grant == S1) ? s1_ar_c : s0_ar_c;
  end

  assign mem.arvalid  = (state == LOCK);
  assign mem.araddr   = mem_ar_c.araddr;
  assign mem.arlen    = mem_ar_c.arlen;
  assign mem.arsize   = mem_ar_c.arsize;
  assign mem.arburst  = mem_ar_c.arburst;
  assign mem.arprot   = mem_ar_c.arprot;
  assign mem.arid     = mem_ar_c.arid;
  assign mem.arcache  = 4'h0;
  assign mem.arlock   = 1'b0;
  assign mem.arqos    = 4'h0;
  assign mem.arregion = 4'h0;
  assign s0.arready   = mem.arready && (grant == S0);
  assign s1.arready   = mem.arready && (grant == S1);

  assign ar_unused = ^{s0.arcache, s0.arlock, s0.arqos, s0.arregion,
                       s1.arcache, s1.arlock, s1.arqos, s1.arregion};

  // R routing by ID mask; s1 mask is tested first, unmatched beats are sunk
  always_comb begin
    hit1_c = (mem.rid & S1_ID_MASK) != '0;
    hit0_c = !hit1_c && ((mem.rid & S0_ID_MASK) != '0);
    rv0_c  = mem.rvalid && hit0_c;
    rv1_c  = mem.rvalid && hit1_c;
  end

  assign s0.rvalid  = rv0_c;
  assign s1.rvalid  = rv1_c;
  assign s0.rid     = mem.rid;
  assign s0.rresp   = mem.rresp;
  assign s0.rdata   = mem.rdata;
  assign s0.rlast   = mem.rlast;
  assign s1.rid     = mem.rid;
  assign s1.rresp   = mem.rresp;
  assign s1.rdata   = mem.rdata;
  assign s1.rlast   = mem.rlast;
  assign mem.rready = hit1_c ? s1.rready : (hit0_c ? s0.rready : 1'b1);
  assign rid_err    = mem.rvalid && !hit0_c && !hit1_c;

  // Outstanding-read bookkeeping; beats arriving with a zero count do not wrap
  always_comb begin
    ar_hs_c = (state == LOCK) && mem.arready;
    inc0_c  = ar_hs_c && (grant == S0);
    inc1_c  = ar_hs_c && (grant == S1);
    dec0_c  = rv0_c && s0.rready && mem.rlast && (cnt0 != '0);
    dec1_c  = rv1_c && s1.rready && mem.rlast && (cnt1 != '0);
  end

  // Per-requester outstanding counters
  always_ff @(posedge aclk) begin
    if (srst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      case ({inc0_c, dec0_c})
        2'b10:   cnt0 <= cnt0 + CNT_W'(1);
        2'b01:   cnt0 <= cnt0 - CNT_W'(1);
        default: cnt0 <= cnt0;
      endcase
      case ({inc1_c, dec1_c})
        2'b10:   cnt1 <= cnt1 + CNT_W'(1);
        2'b01:   cnt1 <= cnt1 - CNT_W'(1);
        default: cnt1 <= cnt1;
      endcase
    end
  end

endmodule

// File: tb/tb_friscv_mem_rd_arbiter.sv
// Bench for friscv_mem_rd_arbiter: directed scenarios plus random traffic
// checked every cycle against a behavioural model of the arbiter.
module tb_friscv_mem_rd_arbiter;
  import friscv_arb_pkg::*;

  localparam int unsigned         OSTD = 4;
  localparam logic [AXI_ID_W-1:0] M0   = 8'h10;
  localparam logic [AXI_ID_W-1:0] M1   = 8'h20;
`ifdef FRISCV_ARB_DCACHE_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic aclk = 1'b0;
  logic srst;
  logic rid_err;

  always #5 aclk = ~aclk;

  friscv_mem_rd_arbiter_if s0_if ();
  friscv_mem_rd_arbiter_if s1_if ();
  friscv_mem_rd_arbiter_if mem_if ();

  friscv_mem_rd_arbiter #(
    .OSTDREQ_NUM (OSTD),
    .S0_ID_MASK  (M0),
    .S1_ID_MASK  (M1)
  ) dut (
    .aclk    (aclk),
    .srst    (srst),
    .s0      (s0_if),
    .s1      (s1_if),
    .mem     (mem_if),
    .rid_err (rid_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: who holds the memory AR port (-1 none), who wins the next tie, outstanding reads
  int m_owner  = -1;
  int m_next   = 0;
  int m_cnt[2] = '{0, 0};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int route(input logic [AXI_ID_W-1:0] id);
    if ((id & M1) != '0) return 1;
    if ((id & M0) != '0) return 0;
    return -1;
  endfunction

  // Compare every DUT output against what the model says it must be this cycle
  task automatic model_check();
    int   tgt;
    logic rv0, rv1, mrr;
    tgt = route(mem_if.rid);
    rv0 = mem_if.rvalid && (tgt == 0);
    rv1 = mem_if.rvalid && (tgt == 1);
    mrr = (tgt == 1) ? s1_if.rready : ((tgt == 0) ? s0_if.rready : 1'b1);
    chk("mem_arvalid", 128'(mem_if.arvalid), 128'(m_owner >= 0));
    chk("s0_arready", 128'(s0_if.arready), 128'((m_owner == 0) && mem_if.arready));
    chk("s1_arready", 128'(s1_if.arready), 128'((m_owner == 1) && mem_if.arready));
    if (m_owner == 0)
      chk("mem_ar_s0", 128'({mem_if.araddr, mem_if.arlen, mem_if.arsize, mem_if.arburst, mem_if.arprot, mem_if.arid}),
          128'({s0_if.araddr, s0_if.arlen, s0_if.arsize, s0_if.arburst, s0_if.arprot, s0_if.arid}));
    if (m_owner == 1)
      chk("mem_ar_s1", 128'({mem_if.araddr, mem_if.arlen, mem_if.arsize, mem_if.arburst, mem_if.arprot, mem_if.arid}),
          128'({s1_if.araddr, s1_if.arlen, s1_if.arsize, s1_if.arburst, s1_if.arprot, s1_if.arid}));
    chk("mem_ar_tied", 128'({mem_if.arlock, mem_if.arcache, mem_if.arqos, mem_if.arregion}), 128'(0));
    chk("s0_rvalid", 128'(s0_if.rvalid), 128'(rv0));
    chk("s1_rvalid", 128'(s1_if.rvalid), 128'(rv1));
    chk("mem_rready", 128'(mem_if.rready), 128'(mrr));
    chk("rid_err", 128'(rid_err), 128'(mem_if.rvalid && (tgt < 0)));
    if (rv0) begin
      chk("s0_rdata", s0_if.rdata, mem_if.rdata);
      chk("s0_rmeta", 128'({s0_if.rid, s0_if.rresp, s0_if.rlast}), 128'({mem_if.rid, mem_if.rresp, mem_if.rlast}));
    end
    if (rv1) begin
      chk("s1_rdata", s1_if.rdata, mem_if.rdata);
      chk("s1_rmeta", 128'({s1_if.rid, s1_if.rresp, s1_if.rlast}), 128'({mem_if.rid, mem_if.rresp, mem_if.rlast}));
    end
  endtask

  // Advance the model across the coming clock edge using the current inputs
  task automatic model_step();
    int   tgt;
    bit   el0, el1, rdy;
    int   w;
    if (srst) begin
      m_owner = -1; m_next = 0; m_cnt[0] = 0; m_cnt[1] = 0;
      return;
    end
    el0 = s0_if.arvalid && (m_cnt[0] < OSTD);
    el1 = s1_if.arvalid && (m_cnt[1] < OSTD);
    tgt = route(mem_if.rid);
    rdy = (tgt == 1) ? s1_if.rready : s0_if.rready;
    if (mem_if.rvalid && (tgt >= 0) && rdy && mem_if.rlast && (m_cnt[tgt] > 0)) m_cnt[tgt]--;
    if (m_owner >= 0) begin
      if (mem_if.arready) begin
        m_cnt[m_owner]++;
        m_owner = -1;
      end
    end else if (el0 || el1) begin
      if (el0 && el1) w = PRIO ? 1 : m_next;
      else            w = el1 ? 1 : 0;
      m_owner = w;
      m_next  = 1 - w;
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    model_check();
    model_step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_idle();
    s0_if.arvalid = 1'b0; s0_if.araddr = '0; s0_if.arlen = '0; s0_if.arsize = '0;
    s0_if.arburst = '0; s0_if.arprot = '0; s0_if.arcache = '0; s0_if.arid = '0;
    s0_if.arlock = 1'b0; s0_if.arqos = '0; s0_if.arregion = '0; s0_if.rready = 1'b0;
    s1_if.arvalid = 1'b0; s1_if.araddr = '0; s1_if.arlen = '0; s1_if.arsize = '0;
    s1_if.arburst = '0; s1_if.arprot = '0; s1_if.arcache = '0; s1_if.arid = '0;
    s1_if.arlock = 1'b0; s1_if.arqos = '0; s1_if.arregion = '0; s1_if.rready = 1'b0;
    mem_if.arready = 1'b0; mem_if.rvalid = 1'b0; mem_if.rid = '0; mem_if.rresp = '0;
    mem_if.rdata = '0; mem_if.rlast = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    srst = 1'b1;
    tick();
    srst = 1'b0;
  endtask

  function automatic logic [AXI_ID_W-1:0] pick_rid();
    case ($urandom_range(0, 5))
      0: return 8'h10;
      1: return 8'h20;
      2: return 8'h30;
      3: return 8'h05;
      4: return 8'h11;
      default: return 8'h00;
    endcase
  endfunction

  task automatic drive_random();
    srst = ($urandom_range(0, 999) < 4);
    s0_if.arvalid = ($urandom_range(0, 99) < 60);
    s0_if.araddr  = AXI_ADDR_W'($urandom); s0_if.arlen = 8'($urandom);
    s0_if.arsize  = 3'($urandom); s0_if.arburst = 2'($urandom); s0_if.arprot = 3'($urandom);
    s0_if.arid    = AXI_ID_W'($urandom); s0_if.arcache = 4'($urandom); s0_if.arlock = 1'($urandom);
    s0_if.arqos   = 4'($urandom); s0_if.arregion = 4'($urandom);
    s0_if.rready  = ($urandom_range(0, 99) < 75);
    s1_if.arvalid = ($urandom_range(0, 99) < 60);
    s1_if.araddr  = AXI_ADDR_W'($urandom); s1_if.arlen = 8'($urandom);
    s1_if.arsize  = 3'($urandom); s1_if.arburst = 2'($urandom); s1_if.arprot = 3'($urandom);
    s1_if.arid    = AXI_ID_W'($urandom); s1_if.arcache = 4'($urandom); s1_if.arlock = 1'($urandom);
    s1_if.arqos   = 4'($urandom); s1_if.arregion = 4'($urandom);
    s1_if.rready  = ($urandom_range(0, 99) < 75);
    mem_if.arready = ($urandom_range(0, 99) < 70);
    mem_if.rvalid  = ($urandom_range(0, 99) < 50);
    mem_if.rid     = pick_rid();
    mem_if.rresp   = 2'($urandom);
    mem_if.rlast   = 1'($urandom);
    mem_if.rdata   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    int got[$];
    int exp_id;

    drive_idle();
    srst = 1'b1;
    @(posedge aclk);
    #1;
    tick();
    chk("rst_mem_arvalid", 128'(mem_if.arvalid), 128'(0));
    chk("rst_s0_arready", 128'(s0_if.arready), 128'(0));
    chk("rst_rid_err", 128'(rid_err), 128'(0));
    chk("rst_state", 128'(dut.state), 128'(IDLE));
    chk("rst_cnt", 128'({dut.cnt0, dut.cnt1}), 128'(0));
    srst = 1'b0;

    // Single s0 read: AR forwarded one cycle later, count up then down on rlast
    do_reset();
    s0_if.arvalid = 1'b1; s0_if.araddr = 10'h100; s0_if.arid = 8'h10; mem_if.arready = 1'b1;
    #1;
    chk("t1_no_same_cycle_ar", 128'(mem_if.arvalid), 128'(0));
    tick();
    chk("t1_mem_arvalid", 128'(mem_if.arvalid), 128'(1));
    chk("t1_mem_araddr", 128'(mem_if.araddr), 128'(10'h100));
    chk("t1_s0_arready", 128'(s0_if.arready), 128'(1));
    tick();
    s0_if.arvalid = 1'b0;
    chk("t1_cnt0_after_ar", 128'(dut.cnt0), 128'(1));
    chk("t1_model_cnt0", 128'(m_cnt[0]), 128'(1));
    mem_if.rvalid = 1'b1; mem_if.rid = 8'h10; mem_if.rlast = 1'b1; s0_if.rready = 1'b1;
    mem_if.rdata = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    #1;
    chk("t1_s0_rvalid", 128'(s0_if.rvalid), 128'(1));
    chk("t1_s1_rvalid", 128'(s1_if.rvalid), 128'(0));
    chk("t1_s0_rdata", s0_if.rdata, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
    tick();
    mem_if.rvalid = 1'b0; mem_if.rlast = 1'b0; s0_if.rready = 1'b0;
    chk("t1_cnt0_after_r", 128'(dut.cnt0), 128'(0));

    // Both requesting continuously: alternate (or always s1 with dcache priority)
    do_reset();
    s0_if.arvalid = 1'b1; s0_if.arid = 8'h10; s0_if.araddr = 10'h040;
    s1_if.arvalid = 1'b1; s1_if.arid = 8'h20; s1_if.araddr = 10'h080;
    mem_if.arready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      tick();
      if (mem_if.arvalid) got.push_back(int'(mem_if.arid));
    end
    s0_if.arvalid = 1'b0; s1_if.arvalid = 1'b0;
    chk("t2_grant_count", 128'(got.size()), 128'(4));
    for (int i = 0; i < got.size() && i < 4; i++) begin
      exp_id = PRIO ? 32'h20 : (((i % 2) == 0) ? 32'h10 : 32'h20);
      chk("t2_grant_order", 128'(got[i]), 128'(exp_id));
    end
    tick();

    // Grant to s0 held while memory stalls, even with s1 waiting
    do_reset();
    s0_if.arvalid = 1'b1; s0_if.araddr = 10'h100; s0_if.arid = 8'h10; mem_if.arready = 1'b0;
    tick();
    s1_if.arvalid = 1'b1; s1_if.araddr = 10'h200; s1_if.arid = 8'h20;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t3_hold_addr", 128'(mem_if.araddr), 128'(10'h100));
      chk("t3_s1_arready", 128'(s1_if.arready), 128'(0));
    end
    mem_if.arready = 1'b1;
    #1;
    chk("t3_s0_arready", 128'(s0_if.arready), 128'(1));
    tick();
    s0_if.arvalid = 1'b0;
    tick();
    chk("t3_switch_addr", 128'(mem_if.araddr), 128'(10'h200));
    chk("t3_switch_valid", 128'(mem_if.arvalid), 128'(1));
    tick();
    s1_if.arvalid = 1'b0;

    // s1 fills its four outstanding slots, is blocked, then freed by one rlast
    do_reset();
    s1_if.arvalid = 1'b1; s1_if.arid = 8'h20; s1_if.araddr = 10'h300; mem_if.arready = 1'b1;
    repeat (8) tick();
    chk("t4_cnt1_full", 128'(dut.cnt1), 128'(4));
    chk("t4_model_cnt1", 128'(m_cnt[1]), 128'(4));
    mem_if.arready = 1'b0; s0_if.arvalid = 1'b1; s0_if.arid = 8'h10; s0_if.araddr = 10'h100;
    tick();
    chk("t4_s0_granted", 128'(mem_if.arid), 128'(8'h10));
    tick();
    chk("t4_s1_blocked", 128'(s1_if.arready), 128'(0));
    mem_if.arready = 1'b1;
    tick();
    s0_if.arvalid = 1'b0;
    tick();
    chk("t4_s1_still_blocked", 128'(mem_if.arvalid), 128'(0));
    mem_if.rvalid = 1'b1; mem_if.rid = 8'h20; mem_if.rlast = 1'b1; s1_if.rready = 1'b1;
    tick();
    mem_if.rvalid = 1'b0; mem_if.rlast = 1'b0; s1_if.rready = 1'b0;
    chk("t4_cnt1_dec", 128'(dut.cnt1), 128'(3));
    tick();
    chk("t4_s1_unblocked", 128'(mem_if.arvalid), 128'(1));
    chk("t4_s1_arid", 128'(mem_if.arid), 128'(8'h20));
    tick();
    s1_if.arvalid = 1'b0;

    // R routing corner cases: unmatched ID, both masks set, backpressure
    do_reset();
    mem_if.rvalid = 1'b1; mem_if.rid = 8'h05; mem_if.rlast = 1'b1;
    s0_if.rready = 1'b1; s1_if.rready = 1'b1;
    #1;
    chk("t5_rid_err", 128'(rid_err), 128'(1));
    chk("t5_drop_rready", 128'(mem_if.rready), 128'(1));
    chk("t5_no_rvalid", 128'({s0_if.rvalid, s1_if.rvalid}), 128'(0));
    tick();
    mem_if.rid = 8'h30;
    #1;
    chk("t5_both_masks_to_s1", 128'({s1_if.rvalid, s0_if.rvalid}), 128'(2'b10));
    tick();
    mem_if.rid = 8'h10; s0_if.rready = 1'b0;
    #1;
    chk("t5_backpressure", 128'(mem_if.rready), 128'(0));
    chk("t5_s0_rvalid", 128'(s0_if.rvalid), 128'(1));
    chk("t5_no_err", 128'(rid_err), 128'(0));
    tick();
    drive_idle();

    // Reset while locked with three reads outstanding
    do_reset();
    s0_if.arvalid = 1'b1; s0_if.arid = 8'h10; mem_if.arready = 1'b1;
    repeat (6) tick();
    mem_if.arready = 1'b0;
    tick();
    chk("t6_cnt0_pre", 128'(dut.cnt0), 128'(3));
    chk("t6_locked", 128'(mem_if.arvalid), 128'(1));
    srst = 1'b1;
    tick();
    srst = 1'b0;
    s0_if.arvalid = 1'b0;
    chk("t6_arvalid", 128'(mem_if.arvalid), 128'(0));
    chk("t6_state", 128'(dut.state), 128'(IDLE));
    chk("t6_cnts", 128'({dut.cnt0, dut.cnt1}), 128'(0));
    mem_if.rvalid = 1'b1; mem_if.rid = 8'h10; mem_if.rlast = 1'b1; s0_if.rready = 1'b1;
    #1;
    chk("t6_late_beat_routed", 128'(s0_if.rvalid), 128'(1));
    tick();
    drive_idle();
    chk("t6_cnt0_holds", 128'(dut.cnt0), 128'(0));

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      tick();
    end
    srst = 1'b0;
    drive_idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
